// File: rtl/led_pwm_fader.sv
// led_pwm_fader: two-channel LED PWM driver; each LED fades along a saturating duty ramp toward led_in.
// Latency: led_in -> busy 2 clk; a duty change reaches led_out at the next PWM period boundary plus 1 clk.
// Backpressure: none, led_in is sampled every clock. Define LED_FADE_GAMMA_EN for a quadratic brightness curve.
module led_pwm_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned RAMP_DIV = 49_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] led_in,
  output logic [1:0] led_out,
  output logic       busy
);

  // RAMP_DIV of 1 still needs a 1-bit step counter that is permanently at its last value.
  localparam int unsigned         STEP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned         SQ_W      = 2 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(RAMP_DIV - 1);

  logic [1:0]               led_in_q, led_in_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]        step_cnt_q, step_cnt_d;
  logic [1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0][PWM_BITS-1:0] duty_lat_q, duty_lat_d;
  logic [1:0][PWM_BITS-1:0] cmp;
  logic [1:0]               led_out_q, led_out_d;
  logic                     busy_q, busy_d;
  logic                     step_tick;
  logic                     period_end;

  // Shared timebase: free-running PWM counter and the ramp-rate divider.
  always_comb begin
    step_tick  = (step_cnt_q == STEP_LAST);
    period_end = (pwm_cnt_q == DUTY_MAX);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    step_cnt_d = step_tick ? '0 : step_cnt_q + STEP_W'(1);
    led_in_d   = led_in;
  end

  // Saturating duty ramp per channel; direction follows the registered target on each step tick.
  always_comb begin
    duty_d = duty_q;
    for (int i = 0; i < 2; i++) begin
      if (step_tick) begin
        if (led_in_q[i] && (duty_q[i] != DUTY_MAX)) begin
          duty_d[i] = duty_q[i] + PWM_BITS'(1);
        end else if (!led_in_q[i] && (duty_q[i] != '0)) begin
          duty_d[i] = duty_q[i] - PWM_BITS'(1);
        end
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [1:0][SQ_W-1:0]     duty_sq;
  logic [1:0][PWM_BITS-1:0] cmp_d, cmp_q;

  // Quadratic brightness: top half of duty^2, with full duty pinned to full-on.
  always_comb begin
    duty_sq = '0;
    cmp_d   = '0;
    for (int i = 0; i < 2; i++) begin
      duty_sq[i] = SQ_W'(duty_q[i]) * SQ_W'(duty_q[i]);
      cmp_d[i]   = (duty_q[i] == DUTY_MAX) ? DUTY_MAX : duty_sq[i][SQ_W-1:PWM_BITS];
    end
  end

  // Pipeline stage that keeps the multiplier out of the latch path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= '0;
    end else begin
      cmp_q <= cmp_d;
    end
  end

  assign cmp = cmp_q;
`else
  assign cmp = duty_q;
`endif

  // Compare values only move at the period boundary, so a period never mixes two duties.
  always_comb begin
    duty_lat_d = duty_lat_q;
    if (period_end) begin
      duty_lat_d = cmp;
    end
  end

  // PWM compare (full duty forced constant-on) and the ramp-in-progress flag.
  always_comb begin
    led_out_d = '0;
    busy_d    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      led_out_d[i] = (duty_lat_q[i] == DUTY_MAX) || (pwm_cnt_q < duty_lat_q[i]);
      if (led_in_q[i]) begin
        busy_d = busy_d | (duty_q[i] != DUTY_MAX);
      end else begin
        busy_d = busy_d | (duty_q[i] != '0);
      end
    end
  end

  // State registers; reset clears everything at once, including a ramp in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q   <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      duty_q     <= '0;
      duty_lat_q <= '0;
      led_out_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      led_in_q   <= led_in_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      duty_q     <= duty_d;
      duty_lat_q <= duty_lat_d;
      led_out_q  <= led_out_d;
      busy_q     <= busy_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule
